// File: rtl/spi_shift_reg.sv
// SPI shift datapath: parallel-load TX shift register driving mosi and an RX
// register assembling miso, with launch/sample strobes selected by SPI mode.
module spi_shift_reg (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       ss,
  input  logic       send_data,
  input  logic       receive_data,
  input  logic       lsbfe,
  input  logic       cpha,
  input  logic       cpol,
  input  logic       flag_low,
  input  logic       flag_high,
  input  logic       flags_low,
  input  logic       flags_high,
  input  logic [7:0] data_mosi,
  input  logic       miso,
  output logic       mosi,
  output logic [7:0] data_miso
);

  logic [7:0] tx_reg;
  logic [7:0] rx_reg;
  logic [2:0] tx_cnt;
  logic [2:0] rx_cnt;

  logic       launch;
  logic       sample;
  logic [2:0] tx_idx;
  logic [2:0] rx_idx;

  // Modes 0/3 launch on the falling SCK strobe and sample on the rising one;
  // modes 1/2 swap the roles.
  always_comb begin
    launch = 1'b0;
    sample = 1'b0;
    if (cpol == cpha) begin
      launch = flags_low;
      sample = flag_high;
    end else begin
      launch = flags_high;
      sample = flag_low;
    end
  end

  always_comb begin
    tx_idx = lsbfe ? tx_cnt : (3'd7 - tx_cnt);
    rx_idx = lsbfe ? rx_cnt : (3'd7 - rx_cnt);
  end

  // Transmit path: a load always wins over a launch in the same cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_reg <= '0;
      tx_cnt <= '0;
      mosi   <= 1'b0;
    end else if (send_data) begin
      tx_reg <= data_mosi;
      tx_cnt <= '0;
    end else if (ss) begin
      tx_cnt <= '0;
    end else if (launch) begin
      mosi   <= tx_reg[tx_idx];
      tx_cnt <= tx_cnt + 3'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_reg <= '0;
      rx_cnt <= '0;
    end else if (ss) begin
      rx_cnt <= '0;
    end else if (sample) begin
      rx_reg[rx_idx] <= miso;
      rx_cnt         <= rx_cnt + 3'd1;
    end
  end

  // Captures rx_reg as it stood before any same-cycle sample.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      data_miso <= '0;
    end else if (receive_data) begin
      data_miso <= rx_reg;
    end
  end

endmodule

// File: tb/tb_spi_shift_reg.sv
// Directed self-checking bench for spi_shift_reg.
module tb_spi_shift_reg;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       ss, send_data, receive_data, lsbfe, cpha, cpol;
  logic       flag_low, flag_high, flags_low, flags_high;
  logic [7:0] data_mosi;
  logic       miso;
  logic       mosi;
  logic [7:0] data_miso;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] vec;
  logic       last_mosi;

  spi_shift_reg dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .ss(ss), .send_data(send_data),
    .receive_data(receive_data), .lsbfe(lsbfe), .cpha(cpha), .cpol(cpol),
    .flag_low(flag_low), .flag_high(flag_high), .flags_low(flags_low),
    .flags_high(flags_high), .data_mosi(data_mosi), .miso(miso),
    .mosi(mosi), .data_miso(data_miso)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] d);
    data_mosi = d;
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0; ss = 1'b0; send_data = 1'b0; receive_data = 1'b0;
    lsbfe = 1'b1; cpha = 1'b0; cpol = 1'b0;
    flag_low = 1'b0; flag_high = 1'b0; flags_low = 1'b0; flags_high = 1'b0;
    data_mosi = '0; miso = 1'b0;
    #3;
    check("reset_mosi", {7'b0, mosi}, 8'h00);
    check("reset_data_miso", data_miso, 8'h00);
    tick(); tick();
    PRESETn = 1'b1;
    tick();

    // Mode 0, LSB first, 0xAA -> 0,1,0,1,0,1,0,1
    load(8'hAA);
    vec = 8'b1010_1010;
    for (int i = 0; i < 8; i++) begin
      flags_low = 1'b1; tick(); flags_low = 1'b0;
      check($sformatf("m0_lsb_bit%0d", i), {7'b0, mosi}, {7'b0, vec[i]});
    end

    // Mode 0, MSB first, plus 9th pulse wraps back to bit 7
    lsbfe = 1'b0;
    load(8'hAA);
    for (int i = 0; i < 8; i++) begin
      flags_low = 1'b1; tick(); flags_low = 1'b0;
      check($sformatf("m0_msb_bit%0d", i), {7'b0, mosi}, {7'b0, ((i % 2) == 0)});
    end
    flags_low = 1'b1; tick(); flags_low = 1'b0;
    check("m0_msb_wrap", {7'b0, mosi}, 8'h01);

    // Receive: flag_low alone is not the mode-0 sample strobe
    lsbfe = 1'b1;
    miso = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flag_low = 1'b1; tick(); flag_low = 1'b0;
    end
    receive_data = 1'b1; tick(); receive_data = 1'b0;
    check("rx_flag_low_ignored", data_miso, 8'h00);

    vec = 8'b1100_1100;
    for (int i = 0; i < 8; i++) begin
      miso = vec[i];
      flag_high = 1'b1; tick(); flag_high = 1'b0;
    end
    check("rx_hold_without_receive", data_miso, 8'h00);
    receive_data = 1'b1; tick(); receive_data = 1'b0;
    check("rx_mode0_lsb_cc", data_miso, 8'hCC);

    // receive_data coinciding with a sample takes pre-update rx_reg
    miso = 1'b1;
    flag_high = 1'b1; receive_data = 1'b1; tick();
    flag_high = 1'b0; receive_data = 1'b0;
    check("rx_coincide_pre", data_miso, 8'hCC);
    receive_data = 1'b1; tick(); receive_data = 1'b0;
    check("rx_coincide_post", data_miso, 8'hCD);

    // Mode 1, MSB first, 0x3C on flags_high; flags_low ignored.
    // Simultaneous sample on flag_low assembles 0x96 MSB first.
    ss = 1'b1; tick(); ss = 1'b0;
    cpha = 1'b1; lsbfe = 1'b0;
    load(8'h3C);
    last_mosi = 1'b1;
    vec = 8'h96;
    for (int i = 0; i < 8; i++) begin
      flags_low = 1'b1; tick(); flags_low = 1'b0;
      check($sformatf("m1_flags_low_ignored%0d", i), {7'b0, mosi}, {7'b0, last_mosi});
      miso = vec[7-i];
      flags_high = 1'b1; flag_low = 1'b1; tick();
      flags_high = 1'b0; flag_low = 1'b0;
      last_mosi = (i >= 2 && i <= 5);
      check($sformatf("m1_msb_bit%0d", i), {7'b0, mosi}, {7'b0, last_mosi});
    end
    receive_data = 1'b1; tick(); receive_data = 1'b0;
    check("m1_rx_simultaneous", data_miso, 8'h96);

    // send_data beats a same-cycle launch; next launch starts at bit 7
    data_mosi = 8'h81;
    send_data = 1'b1; flags_high = 1'b1; tick();
    send_data = 1'b0; flags_high = 1'b0;
    check("send_priority_hold", {7'b0, mosi}, 8'h00);
    flags_high = 1'b1; tick(); flags_high = 1'b0;
    check("send_priority_first", {7'b0, mosi}, 8'h01);

    // ss=1 blocks launches and clears the bit counter
    cpha = 1'b0; lsbfe = 1'b1;
    load(8'h05);
    flags_low = 1'b1; tick();
    check("ss_pre_bit0", {7'b0, mosi}, 8'h01);
    tick(); flags_low = 1'b0;
    check("ss_pre_bit1", {7'b0, mosi}, 8'h00);
    ss = 1'b1; flags_low = 1'b1; flag_high = 1'b1; miso = 1'b1;
    tick(); tick(); tick();
    flags_low = 1'b0; flag_high = 1'b0;
    check("ss_high_hold", {7'b0, mosi}, 8'h00);
    ss = 1'b0;
    flags_low = 1'b1; tick();
    check("ss_restart_bit0", {7'b0, mosi}, 8'h01);
    tick(); flags_low = 1'b0;
    check("ss_restart_bit1", {7'b0, mosi}, 8'h00);

    // Reset mid-transfer, then restart at bit 0
    lsbfe = 1'b0;
    load(8'hF0);
    for (int i = 0; i < 4; i++) begin
      flags_low = 1'b1; tick(); flags_low = 1'b0;
    end
    check("pre_reset_mosi", {7'b0, mosi}, 8'h01);
    #2 PRESETn = 1'b0;
    #1;
    check("midreset_mosi", {7'b0, mosi}, 8'h00);
    check("midreset_data_miso", data_miso, 8'h00);
    #2 PRESETn = 1'b1;
    tick();
    flags_low = 1'b1; tick(); flags_low = 1'b0;
    check("post_reset_tx_cleared", {7'b0, mosi}, 8'h00);
    receive_data = 1'b1; tick(); receive_data = 1'b0;
    check("post_reset_rx_cleared", data_miso, 8'h00);
    lsbfe = 1'b1;
    load(8'h01);
    flags_low = 1'b1; tick();
    check("post_reset_bit0", {7'b0, mosi}, 8'h01);
    tick(); flags_low = 1'b0;
    check("post_reset_bit1", {7'b0, mosi}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
